spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_shift_reg.sv | 44 ++++
 rtl/spi_master.sv | 112 +++++++++++
 tb/tb_spi_master.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared types and defaults for the SPI master slice
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

   localparam int SPI_DATA_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_shift_reg.sv
// ============================================================================
// spi_shift_reg : parallel-load, serial-in/serial-out shift register (MSB out)
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_shift_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   input  logic                  shift_i,
   input  logic                  ser_i,
   output logic [DATA_WIDTH-1:0] q_o
);

   logic [DATA_WIDTH-1:0] shreg_q;
   logic [DATA_WIDTH-1:0] shreg_d;

   // Load takes priority so a new transfer always starts from fresh data.
   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = load_data_i;
      end else if (shift_i) begin
         shreg_d = {shreg_q[DATA_WIDTH-2:0], ser_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign q_o = shreg_q;

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// spi_master : SPI master serialiser/deserialiser, one transfer per CS-low.
// Build option SPI_MASTER_LOOPBACK_EN feeds MOSI back into the shift input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_WIDTH_DEFAULT
) (
   input  logic                  sclk,
   input  logic                  reset,
   input  logic                  MISO,
   input  logic                  CS,
   input  logic [DATA_WIDTH-1:0] MDS,
   output logic [DATA_WIDTH-1:0] MDO,
   output logic                  MOSI
);

   localparam int              CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  mdo_q, mdo_d;
   logic [DATA_WIDTH-1:0]  shreg_q;
   logic                   load;
   logic                   shift;
   logic                   ser_in;

`ifdef SPI_MASTER_LOOPBACK_EN
   // Shifting only happens in SHIFT, where MOSI equals the register MSB.
   logic unused_miso;
   assign unused_miso = MISO;
   assign ser_in      = shreg_q[DATA_WIDTH-1];
`else
   assign ser_in      = MISO;
`endif

   spi_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shreg (
      .clk_i       (sclk),
      .rst_i       (reset),
      .load_i      (load),
      .load_data_i (MDS),
      .shift_i     (shift),
      .ser_i       (ser_in),
      .q_o         (shreg_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mdo_d   = mdo_q;
      load    = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!CS) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (CS) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               shift = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  // Final bit: publish the word including this edge's sample.
                  mdo_d   = {shreg_q[DATA_WIDTH-2:0], ser_in};
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (CS) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sclk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mdo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mdo_q   <= mdo_d;
      end
   end

   assign MOSI = (state_q == SHIFT) ? shreg_q[DATA_WIDTH-1] : 1'b0;
   assign MDO  = mdo_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// tb_spi_master : directed self-checking bench for spi_master
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_master;

   logic       sclk;
   logic       reset;
   logic       MISO;
   logic       CS;
   logic [7:0] MDS;
   logic [7:0] MDO;
   logic       MOSI;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] mdo_exp;

   spi_master #(.DATA_WIDTH(8)) dut (
      .sclk  (sclk),
      .reset (reset),
      .MISO  (MISO),
      .CS    (CS),
      .MDS   (MDS),
      .MDO   (MDO),
      .MOSI  (MOSI)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rx_exp(input logic [7:0] mds, input logic [7:0] slv);
`ifdef SPI_MASTER_LOOPBACK_EN
      return mds;
`else
      return slv;
`endif
   endfunction

   // Starts from CS=1 just after an edge; leaves CS low in DONE.
   task automatic xfer(input logic [7:0] mds, input logic [7:0] slv);
      MDS = mds;
      CS  = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         chk("mosi_bit", {7'd0, MOSI}, {7'd0, mds[7-i]});
         chk("mdo_hold", MDO, mdo_exp);
         MISO = slv[7-i];
         MDS  = ~mds;
         step();
      end
      mdo_exp = rx_exp(mds, slv);
      chk("mdo_done", MDO, mdo_exp);
      chk("mosi_done", {7'd0, MOSI}, 8'd0);
   endtask

   initial begin
      reset   = 1'b1;
      CS      = 1'b0;
      MDS     = 8'hFF;
      MISO    = 1'b1;
      mdo_exp = 8'h00;

      // Reset held with CS low: nothing must start.
      for (int i = 0; i < 10; i++) begin
         step();
         chk("rst_mosi", {7'd0, MOSI}, 8'd0);
      end
      chk("rst_mdo", MDO, 8'h00);
      CS    = 1'b1;
      reset = 1'b0;
      step();
      chk("idle_mosi", {7'd0, MOSI}, 8'd0);

      // Basic transfer
      xfer(8'hA5, 8'h3C);

      // CS stays low: no retrigger
      for (int i = 0; i < 30; i++) begin
         MDS  = 8'(i * 37);
         MISO = i[0];
         step();
         chk("done_mosi", {7'd0, MOSI}, 8'd0);
         chk("done_mdo", MDO, mdo_exp);
      end
      CS = 1'b1;
      step();
      chk("gap_mdo", MDO, mdo_exp);

      // Abort after 4 bits
      MDS = 8'hFF;
      MISO = 1'b1;
      CS  = 1'b0;
      step();
      chk("abort_mosi0", {7'd0, MOSI}, 8'd1);
      repeat (4) step();
      CS = 1'b1;
      step();
      chk("abort_mosi", {7'd0, MOSI}, 8'd0);
      chk("abort_mdo", MDO, mdo_exp);
      step();
      chk("abort_mdo2", MDO, mdo_exp);

      xfer(8'h5A, 8'hC3);
      CS = 1'b1;
      step();

      // Reset in the middle of a transfer
      MDS = 8'h81;
      CS  = 1'b0;
      MISO = 1'b1;
      step();
      repeat (3) step();
      reset = 1'b1;
      step();
      mdo_exp = 8'h00;
      chk("midrst_mdo", MDO, 8'h00);
      chk("midrst_mosi", {7'd0, MOSI}, 8'd0);
      reset = 1'b0;
      CS    = 1'b1;
      step();
      chk("postrst_mosi", {7'd0, MOSI}, 8'd0);
      chk("postrst_mdo", MDO, 8'h00);

      // Loopback pattern: MISO tied low
      MISO = 1'b0;
      MDS  = 8'h96;
      CS   = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         chk("lb_mosi", {7'd0, MOSI}, {7'd0, (8'h96 >> (7 - i)) & 8'h01});
         MDS = 8'h00;
         step();
      end
`ifdef SPI_MASTER_LOOPBACK_EN
      chk("lb_mdo", MDO, 8'h96);
`else
      chk("lb_mdo", MDO, 8'h00);
`endif
      CS = 1'b1;
      step();

      mdo_exp = MDO;
      xfer(8'h00, 8'hFF);
      CS = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
